// File: rtl/pulse_conditioner.sv
// Multi-channel photodiode pulse conditioner: synchronize, integrate-debounce,
// detect edges with a per-channel re-trigger holdoff, and count accepted edges.
module pulse_conditioner #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned HISTORY_SIZE = 25,
  parameter int unsigned HOLDOFF      = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       pulse_in,
  input  logic [1:0]            edge_mode,
  input  logic                  clear_counts,
  output logic [N_CH-1:0]       filtered,
  output logic [N_CH-1:0]       is_edge,
  output logic [N_CH*CNT_W-1:0] edge_ct,
  output logic [N_CH-1:0]       overflow
);

  localparam int unsigned IW = $clog2(HISTORY_SIZE + 1);
  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  localparam logic [IW-1:0]    IntMax  = IW'(HISTORY_SIZE);
  localparam logic [IW-1:0]    IntOne  = IW'(1);
  localparam logic [HW-1:0]    HoldMax = HW'(HOLDOFF);
  localparam logic [HW-1:0]    HoldOne = HW'(1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [N_CH-1:0]  filtered_d, filtered_q;
  logic [N_CH-1:0]  prev_q;
  logic [N_CH-1:0]  is_edge_d, is_edge_q;
  logic [N_CH-1:0]  overflow_d, overflow_q;
  logic [IW-1:0]    integ_d [N_CH];
  logic [IW-1:0]    integ_q [N_CH];
  logic [HW-1:0]    holdoff_d [N_CH];
  logic [HW-1:0]    holdoff_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];

  always_comb begin
    filtered_d = filtered_q;
    is_edge_d  = '0;
    overflow_d = overflow_q;
    for (int i = 0; i < N_CH; i++) begin
      integ_d[i]   = integ_q[i];
      holdoff_d[i] = holdoff_q[i];
      cnt_d[i]     = cnt_q[i];

      if (sync2_q[i]) begin
        if (integ_q[i] != IntMax) integ_d[i] = integ_q[i] + IntOne;
      end else if (integ_q[i] != '0) begin
        integ_d[i] = integ_q[i] - IntOne;
      end

      // Hysteresis: only the saturation extremes move the debounced level.
      if (integ_d[i] == IntMax) begin
        filtered_d[i] = 1'b1;
      end else if (integ_d[i] == '0) begin
        filtered_d[i] = 1'b0;
      end

      is_edge_d[i] = ((edge_mode[0] & filtered_q[i] & ~prev_q[i]) |
                      (edge_mode[1] & ~filtered_q[i] & prev_q[i])) &
                     (holdoff_q[i] == '0);

      if (is_edge_d[i]) begin
        holdoff_d[i] = HoldMax;
      end else if (holdoff_q[i] != '0) begin
        holdoff_d[i] = holdoff_q[i] - HoldOne;
      end

      // Clear takes priority and swallows a coincident edge.
      if (clear_counts) begin
        cnt_d[i]      = '0;
        overflow_d[i] = 1'b0;
      end else if (is_edge_d[i]) begin
        if (cnt_q[i] == CntMax) overflow_d[i] = 1'b1;
        else                    cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filtered_q <= '0;
      prev_q     <= '0;
      is_edge_q  <= '0;
      overflow_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        integ_q[i]   <= '0;
        holdoff_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
    end else begin
      sync1_q    <= pulse_in;
      sync2_q    <= sync1_q;
      filtered_q <= filtered_d;
      prev_q     <= filtered_q;
      is_edge_q  <= is_edge_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < N_CH; i++) begin
        integ_q[i]   <= integ_d[i];
        holdoff_q[i] <= holdoff_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
    end
  end

  always_comb begin
    edge_ct = '0;
    for (int i = 0; i < N_CH; i++) begin
      edge_ct[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign filtered = filtered_q;
  assign is_edge  = is_edge_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner: default build, a shallow filter build
// for holdoff spacing, and a narrow-counter build for saturation and clear.
module tb_pulse_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default-parameter instance
  logic        rst_a = 1'b1, clr_a = 1'b0;
  logic [3:0]  pin_a = '0, filt_a, ise_a, ov_a;
  logic [1:0]  mode_a = 2'b00;
  logic [63:0] ct_a;

  // HISTORY_SIZE=2 instance
  logic        rst_bc = 1'b1, clr_b = 1'b0;
  logic [3:0]  pin_b = '0, filt_b, ise_b, ov_b;
  logic [1:0]  mode_b = 2'b00;
  logic [63:0] ct_b;

  // CNT_W=4 instance
  logic        clr_c = 1'b0;
  logic [3:0]  pin_c = '0, filt_c, ise_c, ov_c;
  logic [1:0]  mode_c = 2'b00;
  logic [15:0] ct_c;

  pulse_conditioner dut_a (
    .clk(clk), .rst(rst_a), .pulse_in(pin_a), .edge_mode(mode_a), .clear_counts(clr_a),
    .filtered(filt_a), .is_edge(ise_a), .edge_ct(ct_a), .overflow(ov_a)
  );

  pulse_conditioner #(.HISTORY_SIZE(2)) dut_b (
    .clk(clk), .rst(rst_bc), .pulse_in(pin_b), .edge_mode(mode_b), .clear_counts(clr_b),
    .filtered(filt_b), .is_edge(ise_b), .edge_ct(ct_b), .overflow(ov_b)
  );

  pulse_conditioner #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst_bc), .pulse_in(pin_c), .edge_mode(mode_c), .clear_counts(clr_c),
    .filtered(filt_c), .is_edge(ise_c), .edge_ct(ct_c), .overflow(ov_c)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic seen_glitch;
  int   hits;
  int   hit_at [4];

  initial begin
    step(2);
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    chk("reset_filtered", {60'd0, filt_a}, 64'd0);
    chk("reset_is_edge", {60'd0, ise_a}, 64'd0);
    chk("reset_edge_ct", ct_a, 64'd0);
    chk("reset_overflow", {60'd0, ov_a}, 64'd0);

    // Rising mode, channel 0 held high for 40 cycles.
    mode_a   = 2'b01;
    pin_a[0] = 1'b1;
    step(26);
    chk("rise_edge26_filtered", {60'd0, filt_a}, 64'd0);
    step(1);
    chk("rise_edge27_filtered", {60'd0, filt_a}, 64'd1);
    chk("rise_edge27_is_edge", {60'd0, ise_a}, 64'd0);
    step(1);
    chk("rise_edge28_is_edge", {60'd0, ise_a}, 64'd1);
    chk("rise_edge28_count", ct_a, 64'd1);
    step(1);
    chk("rise_edge29_is_edge", {60'd0, ise_a}, 64'd0);
    step(11);
    pin_a[0] = 1'b0;
    step(30);
    chk("fall_ignored_filtered", {60'd0, filt_a}, 64'd0);
    chk("fall_ignored_count", ct_a, 64'd1);

    // Glitch train on channel 1: never reaches saturation.
    seen_glitch = 1'b0;
    for (int c = 0; c < 200; c++) begin
      pin_a[1] = ((c / 10) % 2) == 0;
      step(1);
      seen_glitch |= filt_a[1];
    end
    pin_a[1] = 1'b0;
    chk("glitch_filtered", {63'd0, seen_glitch}, 64'd0);
    chk("glitch_count", ct_a, 64'd1);

    // Clear coincident with an accepted edge: clear wins.
    mode_a   = 2'b11;
    pin_a[0] = 1'b1;
    step(27);
    chk("clr_pre_filtered", {60'd0, filt_a}, 64'd1);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    chk("clr_is_edge", {60'd0, ise_a}, 64'd1);
    chk("clr_count", ct_a, 64'd0);

    // Reset during held-high input, then recovery.
    step(5);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    chk("rst_filtered", {60'd0, filt_a}, 64'd0);
    chk("rst_is_edge", {60'd0, ise_a}, 64'd0);
    chk("rst_count", ct_a, 64'd0);
    chk("rst_overflow", {60'd0, ov_a}, 64'd0);
    step(26);
    chk("rerise_edge26", {60'd0, filt_a}, 64'd0);
    step(1);
    chk("rerise_edge27", {60'd0, filt_a}, 64'd1);
    step(1);
    chk("rerise_is_edge", {60'd0, ise_a}, 64'd1);
    chk("rerise_count", ct_a, 64'd1);
    pin_a[0] = 1'b0;

    // Holdoff: HISTORY_SIZE=2, both edges, channel 2 toggled every 4 cycles.
    mode_b = 2'b11;
    hits   = 0;
    for (int k = 0; k < 4; k++) hit_at[k] = 0;
    for (int e = 1; e <= 80; e++) begin
      pin_b[2] = (e <= 48) && ((((e - 1) / 4) % 2) == 0);
      step(1);
      if (ise_b[2]) begin
        if (hits < 4) hit_at[hits] = e;
        hits++;
      end
    end
    chk("holdoff_hits", 64'(hits), 64'd3);
    chk("holdoff_first", 64'(hit_at[0]), 64'd5);
    chk("holdoff_second", 64'(hit_at[1]), 64'd25);
    chk("holdoff_third", 64'(hit_at[2]), 64'd45);
    chk("holdoff_count", ct_b, {16'd0, 16'd3, 32'd0});

    // Saturation on a 4-bit counter, channel 3.
    mode_c = 2'b11;
    for (int k = 1; k <= 17; k++) begin
      pin_c[3] = (k % 2) == 1;
      step(30);
      if (k == 1) chk("sat_edge1_count", {48'd0, ct_c}, {48'd0, 16'h1000});
      if (k == 15) begin
        chk("sat_edge15_count", {48'd0, ct_c}, {48'd0, 16'hF000});
        chk("sat_edge15_overflow", {60'd0, ov_c}, 64'd0);
      end
      if (k == 16) begin
        chk("sat_edge16_count", {48'd0, ct_c}, {48'd0, 16'hF000});
        chk("sat_edge16_overflow", {60'd0, ov_c}, 64'h8);
      end
      if (k == 17) begin
        chk("sat_edge17_count", {48'd0, ct_c}, {48'd0, 16'hF000});
        chk("sat_edge17_overflow", {60'd0, ov_c}, 64'h8);
      end
    end
    clr_c = 1'b1;
    step(1);
    clr_c = 1'b0;
    chk("sat_clear_count", {48'd0, ct_c}, 64'd0);
    chk("sat_clear_overflow", {60'd0, ov_c}, 64'd0);
    chk("sat_clear_filtered", {60'd0, filt_c}, 64'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
